// File: rtl/enq_route_ctrl.sv
// Enqueue-path routing controller: decodes message heads into one of four destination FIFOs
// and holds that route until the tail. Optional message length limit under ENQ_LEN_CHECK_EN.
module enq_route_ctrl #(
    parameter logic [3:0] LOCAL_ID  = 4'd0,
    parameter int         MAX_FLITS = 8
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [15:0] flit_in,
    input  logic [1:0]  ctrl_in,
    input  logic        valid_in,
    output logic        ready_out,
    input  logic [3:0]  fifo_full,
    output logic [15:0] flit_out,
    output logic [1:0]  ctrl_out,
    output logic        en_dest_fifo,
    output logic [1:0]  dest_fifo,
    output logic        busy,
    output logic        err_pulse
);

    localparam int CNT_W = $clog2(MAX_FLITS + 1);
    localparam logic [CNT_W-1:0] CNT_MAX = {CNT_W{1'b1}};

    typedef enum logic {
        IDLE = 1'b0,
        BUSY = 1'b1
    } state_t;

    state_t           state_r;
    logic [1:0]       cur_dest_r;
    logic [CNT_W-1:0] flit_cnt_r;

    logic [1:0] head_dest_s;
    logic       is_head_s;
    logic       accept_s;
    logic       drop_s;
    logic       len_err_s;

    assign head_dest_s = {(flit_in[15:12] == LOCAL_ID), flit_in[11]};
    assign is_head_s   = (ctrl_in == 2'b00) || (ctrl_in == 2'b01);
    assign accept_s    = valid_in & ready_out;
    assign flit_out    = flit_in;
    assign ctrl_out    = ctrl_in;
    assign busy        = (state_r == BUSY);

`ifdef ENQ_LEN_CHECK_EN
    // A body that would leave no room for the tail closes the message early.
    assign len_err_s = (state_r == BUSY) && (ctrl_in == 2'b10) &&
                       (flit_cnt_r == CNT_W'(MAX_FLITS - 1));
`else
    assign len_err_s = 1'b0;
`endif

    // Route select, back-pressure and drop decision for the presented flit.
    always_comb begin
        dest_fifo = head_dest_s;
        ready_out = 1'b1;
        drop_s    = 1'b0;
        case (state_r)
            IDLE: begin
                dest_fifo = head_dest_s;
                if (is_head_s) begin
                    ready_out = !fifo_full[head_dest_s];
                    drop_s    = 1'b0;
                end else begin
                    ready_out = 1'b1;
                    drop_s    = 1'b1;
                end
            end
            BUSY: begin
                dest_fifo = cur_dest_r;
                if (is_head_s) begin
                    ready_out = 1'b1;
                    drop_s    = 1'b1;
                end else begin
                    ready_out = !fifo_full[cur_dest_r];
                    drop_s    = 1'b0;
                end
            end
            default: begin
                dest_fifo = 2'b00;
                ready_out = 1'b0;
                drop_s    = 1'b0;
            end
        endcase
    end

    assign en_dest_fifo = accept_s & !drop_s;
    assign err_pulse    = accept_s & (drop_s | len_err_s);

    // Message sequencing: state, held destination and flit count.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_r    <= IDLE;
            cur_dest_r <= 2'b00;
            flit_cnt_r <= '0;
        end else if (accept_s) begin
            case (state_r)
                IDLE: begin
                    if (ctrl_in == 2'b01) begin
                        state_r    <= BUSY;
                        cur_dest_r <= head_dest_s;
                        flit_cnt_r <= CNT_W'(1);
                    end else begin
                        state_r <= IDLE;
                    end
                end
                BUSY: begin
                    case (ctrl_in)
                        2'b10: begin
                            if (flit_cnt_r != CNT_MAX) begin
                                flit_cnt_r <= flit_cnt_r + CNT_W'(1);
                            end else begin
                                flit_cnt_r <= flit_cnt_r;
                            end
                            if (len_err_s) begin
                                state_r <= IDLE;
                            end else begin
                                state_r <= BUSY;
                            end
                        end
                        2'b11: begin
                            state_r <= IDLE;
                        end
                        default: begin
                            state_r <= BUSY;
                        end
                    endcase
                end
                default: begin
                    state_r <= IDLE;
                end
            endcase
        end else begin
            state_r <= state_r;
        end
    end

endmodule
